move_tick_sequencer: RTL and testbench

Parametrised movement-tick sequencer for the invader formation. Counts enable strobes from the frame/step timer and emits one-cycle milestone pulses at N runtime-programmable thresholds, a wrap pulse at a configurable period, and a march-direction flag that toggles on every wrap. It sits between the step-rate divider and the formation/sprite position logic, which consumes MARK, WRAP and DIR.

---
 rtl/move_pkg.sv | 17 +
 rtl/mark_cmp.sv | 42 ++++
 rtl/move_tick_sequencer.sv | 114 +++++++++++
 tb/tb_move_tick_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/move_pkg.sv
// move_pkg: shared types and defaults for the invader formation movement logic.
// Provides the sequencer state enum, march-direction encodings and the
// default counter width / wrap period used by the formation blocks.
package move_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    localparam logic DIR_RIGHT  = 1'b0;
    localparam logic DIR_LEFT   = 1'b1;
    localparam int   DEF_CNT_W  = 11;
    localparam int   DEF_PERIOD = 400;

endpackage

// File: rtl/mark_cmp.sv
// mark_cmp: one milestone channel -- threshold register, comparator and pulse register.
// Ports:
//   CLK, Rst      clock, synchronous active-high reset
//   i_load        write i_load_val into the threshold at this edge
//   i_load_val    new threshold value
//   i_adv         the count advances at this edge
//   i_next        value the count takes at this edge when advancing
//   o_mark        one-cycle pulse, coincident with the count reaching the threshold
module mark_cmp
    import move_pkg::*;
#(
    parameter int               CNT_W   = DEF_CNT_W,
    parameter logic [CNT_W-1:0] THR_DEF = '0
)(
    input  logic             CLK,
    input  logic             Rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_adv,
    input  logic [CNT_W-1:0] i_next,
    output logic             o_mark
);

    logic [CNT_W-1:0] r_thr;
    logic             r_mark;

    // The pulse compares against the threshold held before any same-cycle load,
    // so a load can never itself trigger a pulse.
    always_ff @(posedge CLK) begin
        if (Rst) begin
            r_thr  <= THR_DEF;
            r_mark <= 1'b0;
        end else begin
            r_mark <= i_adv && (i_next == r_thr);
            if (i_load)
                r_thr <= i_load_val;
        end
    end

    assign o_mark = r_mark;

endmodule

// File: rtl/move_tick_sequencer.sv
// move_tick_sequencer: counts step-timer strobes and emits milestone, wrap and march-direction outputs.
// Ports:
//   CLK, Rst            clock, synchronous active-high reset
//   START / HALT        enter RUN / leave RUN for PAUSED
//   CLR                 zero the count and DIR
//   EN                  tick strobe, counted only in RUN
//   LOAD, LOAD_IDX/VAL  program a milestone threshold
//   COUNT               current tick count (0..PERIOD-1)
//   MARK                per-channel milestone pulses
//   WRAP                pulse when the count wraps to 0
//   DIR                 march direction, toggles on every wrap
//   RUNNING             high while in RUN
module move_tick_sequencer
    import move_pkg::*;
#(
    parameter int                      CNT_W    = DEF_CNT_W,
    parameter int                      N_MARK   = 2,
    parameter int                      PERIOD   = DEF_PERIOD,
    parameter logic [N_MARK*CNT_W-1:0] MARK_DEF = {11'd300, 11'd124},
    localparam int                     IDX_W    = (N_MARK > 1) ? $clog2(N_MARK) : 1
)(
    input  logic              CLK,
    input  logic              Rst,
    input  logic              START,
    input  logic              HALT,
    input  logic              CLR,
    input  logic              EN,
    input  logic              LOAD,
    input  logic [IDX_W-1:0]  LOAD_IDX,
    input  logic [CNT_W-1:0]  LOAD_VAL,
    output logic [CNT_W-1:0]  COUNT,
    output logic [N_MARK-1:0] MARK,
    output logic              WRAP,
    output logic              DIR,
    output logic              RUNNING
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_running;
    logic [CNT_W-1:0] r_count;
    logic             r_dir;
    logic             r_wrap;
    logic             w_adv;
    logic             w_last;
    logic [CNT_W-1:0] w_next;

    always_ff @(posedge CLK) begin
        if (Rst) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= w_state_nxt == RUN;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = START ? RUN : IDLE;
            RUN:     w_state_nxt = HALT ? PAUSED : RUN;
            PAUSED:  w_state_nxt = START ? RUN : PAUSED;
            default: w_state_nxt = IDLE;
        endcase
    end

    // HALT and CLR both block the tick that shares their cycle.
    assign w_adv  = (r_state == RUN) && EN && !HALT && !CLR;
    assign w_last = r_count == LAST;
    assign w_next = w_last ? '0 : r_count + 1'b1;

    always_ff @(posedge CLK) begin
        if (Rst) begin
            r_count <= '0;
            r_dir   <= DIR_RIGHT;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= w_adv && w_last;
            if (CLR) begin
                r_count <= '0;
                r_dir   <= DIR_RIGHT;
            end else if (w_adv) begin
                r_count <= w_next;
                if (w_last)
                    r_dir <= (r_dir == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
            end
        end
    end

    // Index values beyond N_MARK-1 match no channel and are dropped.
    for (genvar i = 0; i < N_MARK; i++) begin : g_mark
        mark_cmp #(
            .CNT_W   (CNT_W),
            .THR_DEF (MARK_DEF[i*CNT_W +: CNT_W])
        ) u_mark (
            .CLK        (CLK),
            .Rst        (Rst),
            .i_load     (LOAD && (LOAD_IDX == IDX_W'(i))),
            .i_load_val (LOAD_VAL),
            .i_adv      (w_adv),
            .i_next     (w_next),
            .o_mark     (MARK[i])
        );
    end

    assign COUNT   = r_count;
    assign WRAP    = r_wrap;
    assign DIR     = r_dir;
    assign RUNNING = r_running;

endmodule

// File: tb/tb_move_tick_sequencer.sv
// tb_move_tick_sequencer: self-checking bench for move_tick_sequencer with a cycle model and directed sequences.
module tb_move_tick_sequencer;

    localparam int W = 11;
    localparam int N = 2;
    localparam int P = 400;

    logic         CLK = 1'b0;
    logic         Rst, START, HALT, CLR, EN, LOAD;
    logic [0:0]   LOAD_IDX;
    logic [W-1:0] LOAD_VAL;
    logic [W-1:0] COUNT;
    logic [N-1:0] MARK;
    logic         WRAP, DIR, RUNNING;

    move_tick_sequencer #(
        .CNT_W    (W),
        .N_MARK   (N),
        .PERIOD   (P),
        .MARK_DEF ({11'd300, 11'd124})
    ) dut (
        .CLK      (CLK),
        .Rst      (Rst),
        .START    (START),
        .HALT     (HALT),
        .CLR      (CLR),
        .EN       (EN),
        .LOAD     (LOAD),
        .LOAD_IDX (LOAD_IDX),
        .LOAD_VAL (LOAD_VAL),
        .COUNT    (COUNT),
        .MARK     (MARK),
        .WRAP     (WRAP),
        .DIR      (DIR),
        .RUNNING  (RUNNING)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] cnt;
        logic [N-1:0] mark;
        logic         wrap;
        logic         dir;
        logic         run;
    } exp_t;

    typedef struct {
        bit   start, halt, clr, en, load;
        int   idx, val;
        exp_t want;
    } vec_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_st, m_cnt;
    int   m_thr[N];
    bit   m_dir;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, want);
        end
    endtask

    // Drive one cycle; the model predicts the post-edge outputs, which are
    // queued at drive time and popped for comparison after the edge.
    task automatic drv(input bit rst, start, halt, clr, en, load, input int idx, input int val);
        exp_t e, g;
        bit   adv;
        int   nx;
        Rst = rst; START = start; HALT = halt; CLR = clr; EN = en; LOAD = load;
        LOAD_IDX = idx[0:0];
        LOAD_VAL = val[W-1:0];
        e.mark = '0;
        e.wrap = 1'b0;
        if (rst) begin
            m_st = 0; m_cnt = 0; m_dir = 1'b0;
            m_thr[0] = 124; m_thr[1] = 300;
        end else begin
            adv = (m_st == 1) && en && !halt && !clr;
            if (clr) begin
                m_cnt = 0; m_dir = 1'b0;
            end else if (adv) begin
                nx = (m_cnt + 1) % P;
                e.wrap = (nx == 0);
                if (e.wrap) m_dir = !m_dir;
                for (int i = 0; i < N; i++) e.mark[i] = (nx == m_thr[i]);
                m_cnt = nx;
            end
            if (load && idx < N) m_thr[idx] = val;
            if (m_st == 1) begin
                if (halt) m_st = 2;
            end else if (start) m_st = 1;
        end
        e.cnt = m_cnt[W-1:0];
        e.dir = m_dir;
        e.run = (m_st == 1);
        q.push_back(e);
        @(posedge CLK);
        #1;
        g = q.pop_front();
        chk("count", COUNT, g.cnt);
        chk("mark", MARK, g.mark);
        chk("wrap", WRAP, g.wrap);
        chk("dir", DIR, g.dir);
        chk("running", RUNNING, g.run);
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) drv(0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_rst();
        drv(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_start();
        drv(0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic load(input int idx, input int val);
        drv(0, 0, 0, 0, 0, 1, idx, val);
    endtask

    function automatic vec_t mkv(input bit s, h, c, e, l, input int ix, v, ec, em, input bit er);
        vec_t r;
        r.start = s; r.halt = h; r.clr = c; r.en = e; r.load = l;
        r.idx = ix; r.val = v;
        r.want.cnt  = ec[W-1:0];
        r.want.mark = em[N-1:0];
        r.want.wrap = 1'b0;
        r.want.dir  = 1'b0;
        r.want.run  = er;
        return r;
    endfunction

    vec_t tab[15];

    initial begin
        int fired, found, cnt0, n_m0, n_wrap;
        tab[0]  = mkv(0,0,0,1,0, 0,0,   0,0,0);
        tab[1]  = mkv(1,0,0,0,0, 0,0,   0,0,1);
        tab[2]  = mkv(0,0,0,1,0, 0,0,   1,0,1);
        tab[3]  = mkv(0,1,0,1,0, 0,0,   1,0,0);
        tab[4]  = mkv(0,0,0,1,0, 0,0,   1,0,0);
        tab[5]  = mkv(1,1,0,0,0, 0,0,   1,0,1);
        tab[6]  = mkv(0,0,1,1,0, 0,0,   0,0,1);
        tab[7]  = mkv(0,0,0,1,1, 0,2,   1,0,1);
        tab[8]  = mkv(0,0,0,1,0, 0,0,   2,1,1);
        tab[9]  = mkv(0,0,0,1,0, 0,0,   3,0,1);
        tab[10] = mkv(0,0,0,0,1, 0,3,   3,0,1);
        tab[11] = mkv(0,0,0,1,1, 1,4,   4,0,1);
        tab[12] = mkv(0,0,0,1,0, 0,0,   5,0,1);
        tab[13] = mkv(1,1,0,1,0, 0,0,   5,0,0);
        tab[14] = mkv(0,0,0,1,0, 0,0,   5,0,0);

        Rst = 1'b1; START = 0; HALT = 0; CLR = 0; EN = 0; LOAD = 0;
        LOAD_IDX = '0; LOAD_VAL = '0;

        // Reset values
        do_rst();
        chk("rst_count", COUNT, 0);
        chk("rst_mark", MARK, 0);
        chk("rst_running", RUNNING, 0);

        // Directed vector table applied straight after reset
        foreach (tab[i]) begin
            drv(0, tab[i].start, tab[i].halt, tab[i].clr, tab[i].en, tab[i].load, tab[i].idx, tab[i].val);
            chk($sformatf("tab%0d_count", i), COUNT, tab[i].want.cnt);
            chk($sformatf("tab%0d_mark", i), MARK, tab[i].want.mark);
            chk($sformatf("tab%0d_wrap", i), WRAP, tab[i].want.wrap);
            chk($sformatf("tab%0d_run", i), RUNNING, tab[i].want.run);
        end

        // EN held high, default thresholds, two full periods
        do_rst();
        drv(0, 1, 0, 0, 1, 0, 0, 0);
        n_m0 = 0; n_wrap = 0;
        for (int i = 1; i <= 2 * P; i++) begin
            tick(1);
            if (MARK[0]) n_m0++;
            if (WRAP) n_wrap++;
            if (i == 124) chk("run_m0", MARK, 2'b01);
            if (i == 300) chk("run_m1", MARK, 2'b10);
            if (i == 400) begin
                chk("run_wrap", WRAP, 1);
                chk("run_wrap_cnt", COUNT, 0);
                chk("run_dir1", DIR, 1);
            end
        end
        chk("run_dir2", DIR, 0);
        chk("run_n_wrap", n_wrap, 2);
        chk("run_n_m0", n_m0, 2);

        // EN strobed every third cycle
        do_rst();
        do_start();
        fired = 0;
        for (int s = 1; s <= 200 && fired == 0; s++) begin
            tick(1);
            if (MARK[0]) begin
                fired = s;
                chk("strobe_m0_cnt", COUNT, 124);
            end
            idle();
            chk("strobe_frozen", COUNT, s);
            chk("strobe_width", MARK[0], 0);
            idle();
        end
        chk("strobe_m0_at", fired, 124);

        // HALT at 50, strobes while paused, resume
        do_rst();
        do_start();
        tick(50);
        chk("halt_cnt50", COUNT, 50);
        drv(0, 0, 1, 0, 1, 0, 0, 0);
        chk("halt_running", RUNNING, 0);
        chk("halt_cnt", COUNT, 50);
        for (int s = 0; s < 20; s++) begin
            tick(1);
            idle();
        end
        chk("paused_cnt", COUNT, 50);
        do_start();
        chk("resume_running", RUNNING, 1);
        fired = 0;
        for (int s = 1; s <= 200 && fired == 0; s++) begin
            tick(1);
            if (MARK[0]) fired = s;
        end
        chk("resume_m0_after", fired, 74);

        // LOAD interactions
        do_rst();
        do_start();
        tick(10);
        chk("load_cnt10", COUNT, 10);
        load(0, 10);
        chk("load_no_pulse", MARK, 0);
        load(1, 0);
        found = 0;
        for (int s = 0; s < 500 && found == 0; s++) begin
            tick(1);
            if (WRAP) begin
                found = 1;
                chk("thr0_mark1", MARK[1], 1);
                chk("thr0_cnt", COUNT, 0);
            end
        end
        chk("thr0_wrap_seen", found, 1);
        load(0, 500);
        cnt0 = 0;
        for (int s = 0; s < P; s++) begin
            tick(1);
            if (MARK[0]) cnt0++;
        end
        chk("thr500_never", cnt0, 0);

        // CLR together with EN at the last count
        do_rst();
        do_start();
        tick(P);
        chk("clr_dir_pre", DIR, 1);
        tick(P - 1);
        chk("clr_cnt_pre", COUNT, P - 1);
        drv(0, 0, 0, 1, 1, 0, 0, 0);
        chk("clr_cnt", COUNT, 0);
        chk("clr_dir", DIR, 0);
        chk("clr_wrap", WRAP, 0);
        chk("clr_mark", MARK, 0);

        // Reset mid-run discards programmed thresholds
        do_rst();
        do_start();
        load(0, 7);
        tick(200);
        chk("mid_cnt200", COUNT, 200);
        drv(1, 0, 0, 0, 1, 0, 0, 0);
        chk("mid_rst_cnt", COUNT, 0);
        chk("mid_rst_running", RUNNING, 0);
        tick(5);
        chk("mid_idle_cnt", COUNT, 0);
        do_start();
        fired = 0;
        for (int s = 1; s <= 200 && fired == 0; s++) begin
            tick(1);
            if (MARK[0]) fired = s;
        end
        chk("mid_thr_default", fired, 124);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
